// File: rtl/fc_flatten_loader_if.sv
// Stream-in and FC-side handshake bundle for fc_flatten_loader.
// The slave modport is the loader; the master modport is whatever drives it.
interface fc_flatten_loader_if #(
    parameter int DATA_W = 16
) ();
    logic                     start;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     fc_all_end;
    logic                     ex_we;
    logic signed [DATA_W-1:0] ex_value;
    logic [15:0]              ex_addr;
    logic                     fc_enable;
    logic                     busy;
    logic                     done;
    logic [15:0]              sample_cnt;

    modport slave (
        input  start, in_valid, in_data, fc_all_end,
        output in_ready, ex_we, ex_value, ex_addr, fc_enable, busy, done, sample_cnt
    );

    modport master (
        output start, in_valid, in_data, fc_all_end,
        input  in_ready, ex_we, ex_value, ex_addr, fc_enable, busy, done, sample_cnt
    );
endinterface

// File: rtl/fc_flatten_loader.sv
// Flattens pixel-major pooled words into channel-major FC memory, then runs FC to all_end.
// Optional macro FLAT_RELU_EN clamps negative input words to zero before writing.
module fc_flatten_loader #(
    parameter int CHANNELS  = 2,
    parameter int MAP_SIZE  = 7,
    parameter int FLAT_LEN  = 14,
    parameter int BASE_ADDR = 0,
    parameter int DATA_W    = 16
) (
    input logic                clk,
    input logic                reset,
    fc_flatten_loader_if.slave bus
);
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    state_t                   state;
    logic [CNT_W-1:0]         acc_cnt;
    logic [CNT_W-1:0]         ch;
    logic [CNT_W-1:0]         pix;
    logic                     vld_p1;
    logic signed [DATA_W-1:0] data_p1;
    logic [ADDR_W-1:0]        addr_p1;
    logic                     fc_enable_q;
    logic                     busy_q;
    logic                     done_q;
    logic [15:0]              sample_cnt_q;
    logic                     in_ready_c;
    logic                     accept;
    logic [ADDR_W-1:0]        addr_c;

    function automatic logic signed [DATA_W-1:0] relu_fn(input logic signed [DATA_W-1:0] x);
`ifdef FLAT_RELU_EN
        return x[DATA_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    assign in_ready_c = (state == LOAD) && (acc_cnt < CNT_W'(FLAT_LEN));
    assign accept     = in_ready_c && bus.in_valid;
    // Channel-major placement; the 16-bit sum is allowed to wrap.
    assign addr_c     = ADDR_W'(BASE_ADDR) + ADDR_W'(ch * CNT_W'(MAP_SIZE)) + pix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            acc_cnt      <= '0;
            ch           <= '0;
            pix          <= '0;
            vld_p1       <= 1'b0;
            data_p1      <= '0;
            addr_p1      <= '0;
            fc_enable_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            // p1: registered write to FC memory, one cycle after acceptance
            vld_p1 <= accept;
            if (accept) begin
                data_p1 <= relu_fn(bus.in_data);
                addr_p1 <= addr_c;
                acc_cnt <= acc_cnt + CNT_W'(1);
                if (ch == CNT_W'(CHANNELS - 1)) begin
                    ch  <= '0;
                    pix <= pix + CNT_W'(1);
                end else begin
                    ch <= ch + CNT_W'(1);
                end
            end

            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= LOAD;
                        busy_q  <= 1'b1;
                        acc_cnt <= '0;
                        ch      <= '0;
                        pix     <= '0;
                    end
                end
                LOAD: begin
                    // Wait for the final write to be on the bus before handing over to FC.
                    if (vld_p1 && (acc_cnt == CNT_W'(FLAT_LEN))) begin
                        state       <= RUN;
                        fc_enable_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.fc_all_end) begin
                        state        <= FIN;
                        fc_enable_q  <= 1'b0;
                        done_q       <= 1'b1;
                        sample_cnt_q <= sample_cnt_q + 16'd1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.ex_we      = vld_p1;
    assign bus.ex_value   = data_p1;
    assign bus.ex_addr    = addr_p1;
    assign bus.fc_enable  = fc_enable_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sample_cnt = sample_cnt_q;
endmodule

// File: tb/tb_fc_flatten_loader.sv
// Directed/randomized bench for fc_flatten_loader against a flatten-order reference model.
module tb_fc_flatten_loader;
    localparam int CHANNELS  = 2;
    localparam int MAP_SIZE  = 7;
    localparam int FLAT_LEN  = 14;
    localparam int BASE_ADDR = 0;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    fc_flatten_loader_if #(.DATA_W(16)) bus ();

    fc_flatten_loader #(
        .CHANNELS(CHANNELS), .MAP_SIZE(MAP_SIZE), .FLAT_LEN(FLAT_LEN),
        .BASE_ADDR(BASE_ADDR), .DATA_W(16)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_ready, m_we, m_busy, m_loading;
    int          m_k;
    logic [15:0] m_addr, m_val;
    int          m_samples;
    logic [15:0] dat [FLAT_LEN];

    function automatic logic [15:0] relu_ref(input logic [15:0] d);
`ifdef FLAT_RELU_EN
        return d[15] ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    function automatic logic [15:0] addr_ref(input int k);
        return 16'(BASE_ADDR + (k % CHANNELS) * MAP_SIZE + k / CHANNELS);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, m_ready});
        chk("ex_we", {31'd0, bus.ex_we}, {31'd0, m_we});
        if (m_we) begin
            chk("ex_addr", {16'd0, bus.ex_addr}, {16'd0, m_addr});
            chk("ex_value", {16'd0, bus.ex_value}, {16'd0, m_val});
        end
    endtask

    task automatic clk_edge();
        bit          acc;
        logic [15:0] d;
        bit          st;
        acc = m_ready && bus.in_valid;
        d   = bus.in_data;
        st  = bus.start;
        @(posedge clk);
        if (reset) begin
            m_we = 0; m_k = 0; m_loading = 0; m_busy = 0; m_samples = 0;
            m_addr = '0; m_val = '0;
        end else begin
            m_we = acc;
            if (acc) begin
                m_addr = addr_ref(m_k);
                m_val  = relu_ref(d);
                m_k++;
            end
            if (st && !m_busy) begin
                m_busy = 1; m_loading = 1; m_k = 0;
            end
        end
        m_ready = m_loading && (m_k < FLAT_LEN);
        #1;
    endtask

    task automatic tick();
        sample();
        clk_edge();
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        sample();
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        clk_edge();
    endtask

    task automatic load_words(input int n, input bit gaps, input bit inject);
        int budget = 0;
        while (m_k < n && budget < 400) begin
            bus.in_valid   = gaps ? ($urandom_range(0, 2) == 0) : 1'b1;
            bus.in_data    = dat[m_k];
            bus.start      = inject && ($urandom_range(0, 3) == 0);
            bus.fc_all_end = inject && ($urandom_range(0, 3) == 0);
            tick();
            budget++;
        end
        bus.in_valid   = 1'b0;
        bus.start      = 1'b0;
        bus.fc_all_end = 1'b0;
        if (m_k < n) chk("load_budget", m_k, n);
    endtask

    task automatic finish_sample(input int wait_cycles);
        sample();
        chk("fc_en_during_last_we", {31'd0, bus.fc_enable}, 32'd0);
        clk_edge();
        sample();
        chk("fc_en_rise", {31'd0, bus.fc_enable}, 32'd1);
        chk("busy_run", {31'd0, bus.busy}, 32'd1);
        for (int i = 0; i < wait_cycles; i++) begin
            clk_edge();
            sample();
            chk("fc_en_hold", {31'd0, bus.fc_enable}, 32'd1);
            chk("done_low_run", {31'd0, bus.done}, 32'd0);
        end
        bus.fc_all_end = 1'b1;
        clk_edge();
        bus.fc_all_end = 1'b0;
        bus.start      = 1'b1;
        m_samples++;
        sample();
        chk("fc_en_drop", {31'd0, bus.fc_enable}, 32'd0);
        chk("done_pulse", {31'd0, bus.done}, 32'd1);
        chk("busy_fin", {31'd0, bus.busy}, 32'd1);
        chk("sample_cnt", {16'd0, bus.sample_cnt}, m_samples);
        clk_edge();
        bus.start = 1'b0;
        m_busy    = 0;
        m_loading = 0;
        m_ready   = 0;
        sample();
        chk("done_end", {31'd0, bus.done}, 32'd0);
        chk("busy_idle", {31'd0, bus.busy}, 32'd0);
        clk_edge();
        sample();
        chk("start_in_fin_ignored", {31'd0, bus.busy}, 32'd0);
        clk_edge();
    endtask

    task automatic check_reset_outputs();
        sample();
        chk("rst_fc_enable", {31'd0, bus.fc_enable}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_ex_value", {16'd0, bus.ex_value}, 32'd0);
        chk("rst_ex_addr", {16'd0, bus.ex_addr}, 32'd0);
        chk("rst_sample_cnt", {16'd0, bus.sample_cnt}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.fc_all_end = 1'b0;
        m_ready = 0; m_we = 0; m_busy = 0; m_loading = 0; m_k = 0; m_samples = 0;
        m_addr = '0; m_val = '0;
        clk_edge();
        clk_edge();
        check_reset_outputs();
        reset = 1'b0;
        clk_edge();

        // in_valid while idle is never accepted
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h1234;
        bus.fc_all_end = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.in_valid = 1'b0;
        bus.fc_all_end = 1'b0;
        sample();
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);
        clk_edge();

        // Back-to-back 1..14
        for (int i = 0; i < FLAT_LEN; i++) dat[i] = 16'(i + 1);
        do_start();
        load_words(FLAT_LEN, 1'b0, 1'b0);
        finish_sample(20);

        // Random data with in_valid gaps
        for (int i = 0; i < FLAT_LEN; i++) dat[i] = 16'($urandom);
        do_start();
        load_words(FLAT_LEN, 1'b1, 1'b0);
        finish_sample(3);

        // Negative / boundary values
        dat[0] = 16'hFFFF; dat[1] = 16'h8000; dat[2] = 16'h7FFF;
        for (int i = 3; i < FLAT_LEN; i++) dat[i] = 16'($urandom);
        do_start();
        load_words(FLAT_LEN, 1'b1, 1'b0);
        finish_sample(2);

        // start and fc_all_end pulsed during LOAD
        for (int i = 0; i < FLAT_LEN; i++) dat[i] = 16'($urandom);
        do_start();
        load_words(FLAT_LEN, 1'b1, 1'b1);
        finish_sample(5);

        // Reset after 5 accepted words, then a fresh sample
        for (int i = 0; i < FLAT_LEN; i++) dat[i] = 16'($urandom);
        do_start();
        load_words(5, 1'b0, 1'b0);
        reset = 1'b1;
        clk_edge();
        check_reset_outputs();
        clk_edge();
        reset = 1'b0;
        clk_edge();
        do_start();
        load_words(FLAT_LEN, 1'b0, 1'b0);
        finish_sample(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
